// File: rtl/instruction_decode_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, funct codes, branch
// kinds, access widths, ALU operand selects and the packed control bundle.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // REGIMM opcode distinguishes bltz/bgez by the rt field
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [4:0] {
    BR_NONE = 5'd0,
    BR_BEQ  = 5'd1,
    BR_BNE  = 5'd2,
    BR_BGTZ = 5'd3,
    BR_BLEZ = 5'd4,
    BR_BLTZ = 5'd5,
    BR_BGEZ = 5'd6,
    BR_J    = 5'd7,
    BR_JAL  = 5'd8,
    BR_JR   = 5'd9
  } branch_sel_e;

  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_BYTE = 2'b10
  } width_e;

  typedef enum logic [1:0] {
    SRC1_REG  = 2'b00,
    SRC1_IMM  = 2'b01,
    SRC1_ZERO = 2'b10
  } alu_src1_e;

  typedef struct packed {
    logic        reg_dst;
    logic        alu_src0;
    alu_src1_e   alu_src1;
    logic        r_enable;
    logic        w_enable;
    width_e      r_width;
    width_e      w_width;
    logic        mem_to_reg;
    logic        reg_write;
    branch_sel_e branch_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two combinational read ports, one write port,
// synchronous active-low clear. Define DECODE_BYPASS_EN for write-before-read.
module register_file
  import instruction_decode_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [32];

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // $0 is hardwired to zero and both ports read zero while reset is held
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (Reset_n) begin
      if (rs_addr != 5'd0) rs_data = regs[rs_addr];
      if (rt_addr != 5'd0) rt_data = regs[rt_addr];
`ifdef DECODE_BYPASS_EN
      if (wr_en && (wr_addr != 5'd0) && (wr_addr == rs_addr)) rs_data = wr_data;
      if (wr_en && (wr_addr != 5'd0) && (wr_addr == rt_addr)) rt_data = wr_data;
`endif
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: control decode, immediate extension and register file.
// Optional same-cycle writeback bypass is enabled with DECODE_BYPASS_EN.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] Instruction,
  input  logic [4:0]  RegDestSelected_WB,
  input  logic [31:0] RegWriteData_WB,
  input  logic        RegWrite_WB,
  output logic        PCSel,
  output logic        RegDst,
  output logic        ALUSrc0,
  output logic [1:0]  ALUSrc1,
  output logic        R_Enable,
  output logic        W_Enable,
  output logic [1:0]  R_Width,
  output logic [1:0]  W_Width,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic [4:0]  BranchSel,
  output logic [31:0] Reg_Data1,
  output logic [31:0] Reg_Data2,
  output logic [31:0] Imm32b
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  ctrl_t       ctrl;
  ctrl_t       ctrl_out;
  logic        zero_ext;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign funct  = Instruction[5:0];
  assign imm16  = Instruction[15:0];

  always_comb begin
    ctrl     = CTRL_NOP;
    zero_ext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_XOR, FN_SLT: ;
          FN_SLL, FN_SRL: ctrl.alu_src0 = 1'b1;
          FN_JR: begin
            ctrl.reg_write  = 1'b0;
            ctrl.branch_sel = BR_JR;
          end
          default: ctrl = CTRL_NOP;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.alu_src1  = SRC1_IMM;
        ctrl.reg_write = 1'b1;
        zero_ext       = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl.r_enable   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src1   = SRC1_IMM;
        ctrl.r_width    = (opcode == OP_LW) ? WIDTH_WORD :
                          (opcode == OP_LH) ? WIDTH_HALF : WIDTH_BYTE;
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl.w_enable = 1'b1;
        ctrl.alu_src1 = SRC1_IMM;
        ctrl.w_width  = (opcode == OP_SW) ? WIDTH_WORD :
                        (opcode == OP_SH) ? WIDTH_HALF : WIDTH_BYTE;
      end
      OP_BEQ:  ctrl.branch_sel = BR_BEQ;
      OP_BNE:  ctrl.branch_sel = BR_BNE;
      OP_BGTZ: begin
        ctrl.branch_sel = BR_BGTZ;
        ctrl.alu_src1   = SRC1_ZERO;
      end
      OP_BLEZ: begin
        ctrl.branch_sel = BR_BLEZ;
        ctrl.alu_src1   = SRC1_ZERO;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          ctrl.branch_sel = BR_BLTZ;
          ctrl.alu_src1   = SRC1_ZERO;
        end else if (rt == RT_BGEZ) begin
          ctrl.branch_sel = BR_BGEZ;
          ctrl.alu_src1   = SRC1_ZERO;
        end
      end
      OP_J:   ctrl.branch_sel = BR_J;
      // $31 as destination is resolved downstream from BranchSel
      OP_JAL: begin
        ctrl.branch_sel = BR_JAL;
        ctrl.reg_write  = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign ctrl_out = Reset_n ? ctrl : CTRL_NOP;
  assign Imm32b   = zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

  assign PCSel     = (ctrl_out.branch_sel != BR_NONE);
  assign RegDst    = ctrl_out.reg_dst;
  assign ALUSrc0   = ctrl_out.alu_src0;
  assign ALUSrc1   = ctrl_out.alu_src1;
  assign R_Enable  = ctrl_out.r_enable;
  assign W_Enable  = ctrl_out.w_enable;
  assign R_Width   = ctrl_out.r_width;
  assign W_Width   = ctrl_out.w_width;
  assign MemToReg  = ctrl_out.mem_to_reg;
  assign RegWrite  = ctrl_out.reg_write;
  assign BranchSel = ctrl_out.branch_sel;

  register_file u_register_file (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .rs_addr (rs),
    .rt_addr (rt),
    .wr_addr (RegDestSelected_WB),
    .wr_data (RegWriteData_WB),
    .wr_en   (RegWrite_WB),
    .rs_data (Reg_Data1),
    .rt_data (Reg_Data2)
  );

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: table-driven decode model plus
// a register array model, compared every negedge; literal checks pin the model.
module tb_instruction_decode;

  logic        Clock;
  logic        Reset_n;
  logic [31:0] Instruction;
  logic [4:0]  RegDestSelected_WB;
  logic [31:0] RegWriteData_WB;
  logic        RegWrite_WB;
  logic        PCSel, RegDst, ALUSrc0, R_Enable, W_Enable, MemToReg, RegWrite;
  logic [1:0]  ALUSrc1, R_Width, W_Width;
  logic [4:0]  BranchSel;
  logic [31:0] Reg_Data1, Reg_Data2, Imm32b;

  instruction_decode dut (
    .Clock              (Clock),
    .Reset_n            (Reset_n),
    .Instruction        (Instruction),
    .RegDestSelected_WB (RegDestSelected_WB),
    .RegWriteData_WB    (RegWriteData_WB),
    .RegWrite_WB        (RegWrite_WB),
    .PCSel              (PCSel),
    .RegDst             (RegDst),
    .ALUSrc0            (ALUSrc0),
    .ALUSrc1            (ALUSrc1),
    .R_Enable           (R_Enable),
    .W_Enable           (W_Enable),
    .R_Width            (R_Width),
    .W_Width            (W_Width),
    .MemToReg           (MemToReg),
    .RegWrite           (RegWrite),
    .BranchSel          (BranchSel),
    .Reg_Data1          (Reg_Data1),
    .Reg_Data2          (Reg_Data2),
    .Imm32b             (Imm32b)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  // kind: 0 = opcode only, 1 = opcode + funct, 2 = opcode + rt
  typedef struct packed {
    logic [5:0] op;
    logic [1:0] kind;
    logic [5:0] sel;
    logic       regdst;
    logic       alu0;
    logic [1:0] alu1;
    logic       ren;
    logic       wen;
    logic [1:0] rw;
    logic [1:0] ww;
    logic       m2r;
    logic       rwr;
    logic [4:0] bsel;
  } entry_t;

  entry_t tbl[$];
  logic [31:0] m_regs [32];

  task automatic add(input logic [5:0] op, input logic [1:0] kind, input logic [5:0] sel,
                     input logic regdst, input logic alu0, input logic [1:0] alu1,
                     input logic ren, input logic wen, input logic [1:0] rw, input logic [1:0] ww,
                     input logic m2r, input logic rwr, input logic [4:0] bsel);
    entry_t e;
    e = '{op, kind, sel, regdst, alu0, alu1, ren, wen, rw, ww, m2r, rwr, bsel};
    tbl.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    //   op     kind  sel    dst a0 a1 ren wen rw ww m2r rwr bsel
    add(6'h00, 2'd1, 6'h20, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // add
    add(6'h00, 2'd1, 6'h22, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // sub
    add(6'h00, 2'd1, 6'h24, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // and
    add(6'h00, 2'd1, 6'h25, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // or
    add(6'h00, 2'd1, 6'h27, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // nor
    add(6'h00, 2'd1, 6'h26, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // xor
    add(6'h00, 2'd1, 6'h2A, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  // slt
    add(6'h00, 2'd1, 6'h00, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);  // sll
    add(6'h00, 2'd1, 6'h02, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);  // srl
    add(6'h00, 2'd1, 6'h08, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9);  // jr
    add(6'h08, 2'd0, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);  // addi
    add(6'h0A, 2'd0, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);  // slti
    add(6'h0C, 2'd0, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);  // andi
    add(6'h0D, 2'd0, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);  // ori
    add(6'h0E, 2'd0, 6'h00, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);  // xori
    add(6'h23, 2'd0, 6'h00, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0);  // lw
    add(6'h21, 2'd0, 6'h00, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0);  // lh
    add(6'h20, 2'd0, 6'h00, 0, 0, 1, 1, 0, 2, 0, 1, 1, 0);  // lb
    add(6'h2B, 2'd0, 6'h00, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);  // sw
    add(6'h29, 2'd0, 6'h00, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);  // sh
    add(6'h28, 2'd0, 6'h00, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0);  // sb
    add(6'h04, 2'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // beq
    add(6'h05, 2'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);  // bne
    add(6'h07, 2'd0, 6'h00, 0, 0, 2, 0, 0, 0, 0, 0, 0, 3);  // bgtz
    add(6'h06, 2'd0, 6'h00, 0, 0, 2, 0, 0, 0, 0, 0, 0, 4);  // blez
    add(6'h01, 2'd2, 6'h00, 0, 0, 2, 0, 0, 0, 0, 0, 0, 5);  // bltz
    add(6'h01, 2'd2, 6'h01, 0, 0, 2, 0, 0, 0, 0, 0, 0, 6);  // bgez
    add(6'h02, 2'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);  // j
    add(6'h03, 2'd0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);  // jal
  end

  function automatic logic [17:0] model_ctrl(input logic [31:0] w, input logic rstn);
    logic [17:0] r = '0;
    if (!rstn) return r;
    foreach (tbl[i]) begin
      if (tbl[i].op == w[31:26] &&
          (tbl[i].kind == 2'd0 ||
           (tbl[i].kind == 2'd1 && tbl[i].sel == w[5:0]) ||
           (tbl[i].kind == 2'd2 && tbl[i].sel[4:0] == w[20:16]))) begin
        r = {tbl[i].bsel != 5'd0, tbl[i].regdst, tbl[i].alu0, tbl[i].alu1, tbl[i].ren,
             tbl[i].wen, tbl[i].rw, tbl[i].ww, tbl[i].m2r, tbl[i].rwr, tbl[i].bsel};
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w);
    int op = int'(w[31:26]);
    if (op == 'h0C || op == 'h0D || op == 'h0E) return {16'h0, w[15:0]};
    return {{16{w[15]}}, w[15:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!Reset_n || a == 5'd0) return '0;
`ifdef DECODE_BYPASS_EN
    if (RegWrite_WB && RegDestSelected_WB == a) return RegWriteData_WB;
`endif
    return m_regs[a];
  endfunction

  // register model commits on the same edge as the DUT
  always @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (RegWrite_WB && RegDestSelected_WB != 5'd0) begin
      m_regs[RegDestSelected_WB] = RegWriteData_WB;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t instr=%h)", name, act, exp, $time, Instruction);
    end
  endtask

  // scoreboard: compare DUT against the model every cycle
  always @(negedge Clock) begin
    if (check_en) begin
      check("ctrl", {14'b0, PCSel, RegDst, ALUSrc0, ALUSrc1, R_Enable, W_Enable, R_Width,
                     W_Width, MemToReg, RegWrite, BranchSel},
            {14'b0, model_ctrl(Instruction, Reset_n)});
      check("imm", Imm32b, model_imm(Instruction));
      check("rd1", Reg_Data1, model_read(Instruction[25:21]));
      check("rd2", Reg_Data2, model_read(Instruction[20:16]));
    end
  end

  // driver
  task automatic apply(input logic rstn, input logic [31:0] instr, input logic we,
                       input logic [4:0] dest, input logic [31:0] data);
    @(posedge Clock);
    #1;
    Reset_n            = rstn;
    Instruction        = instr;
    RegWrite_WB        = we;
    RegDestSelected_WB = dest;
    RegWriteData_WB    = data;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(1, 0) == 0) return 5'($urandom_range(7, 0));
    return 5'($urandom_range(31, 0));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom();
    entry_t e;
    w[25:21] = rnd_reg();
    w[20:16] = rnd_reg();
    if ($urandom_range(3, 0) != 0) begin
      e = tbl[$urandom_range(tbl.size() - 1, 0)];
      w[31:26] = e.op;
      if (e.kind == 2'd1) w[5:0] = e.sel;
      if (e.kind == 2'd2) w[20:16] = e.sel[4:0];
    end
    return w;
  endfunction

  initial begin
    Reset_n = 1'b0; Instruction = '0; RegWrite_WB = 1'b0;
    RegDestSelected_WB = '0; RegWriteData_WB = '0;

    // reset edge, then read $5/$31
    apply(1'b1, 32'h00BF0820, 1'b0, 5'd0, 32'h0);
    check_en = 1'b1;
    @(negedge Clock);
    check("reset_rd1", Reg_Data1, 32'h0);
    check("reset_rd2", Reg_Data2, 32'h0);

    apply(1'b1, 32'h00BF0820, 1'b1, 5'd8, 32'hDEADBEEF);
    apply(1'b1, 32'h01095020, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    check("add_rd1", Reg_Data1, 32'hDEADBEEF);
    check("add_regdst", {31'b0, RegDst}, 32'd1);
    check("add_regwrite", {31'b0, RegWrite}, 32'd1);
    check("add_alusrc1", {30'b0, ALUSrc1}, 32'd0);
    check("add_branchsel", {27'b0, BranchSel}, 32'd0);

    apply(1'b1, 32'h00000020, 1'b1, 5'd0, 32'h1234);
    apply(1'b1, 32'h00000020, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    check("zero_reg", Reg_Data1, 32'h0);

    apply(1'b1, 32'h8D09FFFC, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    check("lw_imm", Imm32b, 32'hFFFFFFFC);
    check("lw_ren", {31'b0, R_Enable}, 32'd1);
    check("lw_rwidth", {30'b0, R_Width}, 32'd0);
    check("lw_memtoreg", {31'b0, MemToReg}, 32'd1);
    check("lw_alusrc1", {30'b0, ALUSrc1}, 32'd1);
    check("lw_regdst", {31'b0, RegDst}, 32'd0);

    apply(1'b1, 32'h3509FFFC, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    check("ori_imm", Imm32b, 32'h0000FFFC);

    apply(1'b1, 32'h11090003, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    check("beq_pcsel", {31'b0, PCSel}, 32'd1);
    check("beq_branchsel", {27'b0, BranchSel}, 32'd1);
    check("beq_regwrite", {31'b0, RegWrite}, 32'd0);
    check("beq_imm", Imm32b, 32'h3);

    apply(1'b1, 32'h08000010, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    check("j_branchsel", {27'b0, BranchSel}, 32'd7);

    apply(1'b1, 32'h01095020, 1'b1, 5'd8, 32'h55);
    @(negedge Clock);
`ifdef DECODE_BYPASS_EN
    check("bypass_rd1", Reg_Data1, 32'h55);
`else
    check("nobypass_rd1", Reg_Data1, 32'hDEADBEEF);
`endif

    apply(1'b0, 32'h8D09FFFC, 1'b1, 5'd9, 32'h77);
    @(negedge Clock);
    check("reset_ctrl_ren", {31'b0, R_Enable}, 32'd0);
    check("reset_rd1_held", Reg_Data1, 32'h0);

    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(39, 0) != 0), rnd_instr(), 1'($urandom_range(1, 0)),
            rnd_reg(), $urandom());
    end
    apply(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge Clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
